// File: rtl/bisect_scheduler_pkg.sv
// Shared geometry types, scheduler enums and the squared XY edge length helper
// used by the bisect datapath and the subdivision scheduler.
package bisect_scheduler_pkg;

    localparam int COORD_W = 16;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } Point3D;

    typedef struct packed {
        Point3D p;
        Point3D q;
        Point3D r;
    } Triangle3D;

    typedef enum logic [1:0] {EDGE_PQ, EDGE_QR, EDGE_RP} EdgeSel;

    typedef logic [34:0] EdgeLenSq;

    typedef enum logic [2:0] {
        S_IDLE, S_EVAL, S_SPLIT0, S_SPLIT1, S_SPLIT2, S_EMIT
    } sched_state_e;

    // 17-bit differences cannot overflow for 16-bit coordinates; squares are non-negative.
    function automatic EdgeLenSq edge_len_sq(input Point3D a, input Point3D b);
        logic signed [16:0] dx, dy;
        logic signed [33:0] sx, sy;
        dx = 17'(a.x) - 17'(b.x);
        dy = 17'(a.y) - 17'(b.y);
        sx = 34'(dx) * 34'(dx);
        sy = 34'(dy) * 34'(dy);
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/bisect.sv
// Edge bisection datapath: splits tri_in at the midpoint of PQ and registers
// child A (p,mid,r) or child B (mid,q,r) selected by tri_select.
module bisect
    import bisect_scheduler_pkg::*;
(
    input  logic      clk,
    input  Triangle3D tri_in,
    input  logic      tri_select,
    output Triangle3D tri_out
);

    function automatic Point3D midpoint(input Point3D a, input Point3D b);
        logic signed [16:0] sx, sy, sz;
        Point3D m;
        sx = 17'(a.x) + 17'(b.x);
        sy = 17'(a.y) + 17'(b.y);
        sz = 17'(a.z) + 17'(b.z);
        m.x = sx[16:1];
        m.y = sy[16:1];
        m.z = sz[16:1];
        return m;
    endfunction

    Point3D    mid;
    Triangle3D tri_out_q;

    assign mid = midpoint(tri_in.p, tri_in.q);

    always_ff @(posedge clk) begin
        if (tri_select) tri_out_q <= '{p: mid, q: tri_in.q, r: tri_in.r};
        else            tri_out_q <= '{p: tri_in.p, q: mid, r: tri_in.r};
    end

    assign tri_out = tri_out_q;

endmodule

// File: rtl/bisect_scheduler_tri_lifo.sv
// LIFO of pending triangle halves, each tagged with its subdivision depth.
module tri_lifo
    import bisect_scheduler_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 3,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  Triangle3D          push_tri_i,
    input  logic [DEPTH_W-1:0] push_depth_i,
    output Triangle3D          top_tri_o,
    output logic [DEPTH_W-1:0] top_depth_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [CNT_W-1:0]   count_o
);

    Triangle3D          tri_mem_q   [DEPTH];
    logic [DEPTH_W-1:0] depth_mem_q [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rd_idx  = IDX_W'(count_q - CNT_W'(1));
    assign wr_idx  = do_pop ? rd_idx : IDX_W'(count_q);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            tri_mem_q[wr_idx]   <= push_tri_i;
            depth_mem_q[wr_idx] <= push_depth_i;
        end
    end

    assign top_tri_o   = tri_mem_q[rd_idx];
    assign top_depth_o = depth_mem_q[rd_idx];
    assign count_o     = count_q;

endmodule

// File: rtl/bisect_scheduler.sv
// Depth-first recursive subdivision controller: rotates each piece so its
// longest XY edge is PQ, bisects via the bisect datapath, emits leaf triangles.
module bisect_scheduler
    import bisect_scheduler_pkg::*;
#(
    parameter int       MAX_DEPTH   = 4,
    parameter EdgeLenSq MIN_EDGE_SQ = 35'd1024,
    localparam int      DEPTH_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  Triangle3D          tri_in,
    input  logic               in_valid,
    output logic               in_ready,
    output Triangle3D          leaf_out,
    output logic [DEPTH_W-1:0] leaf_depth,
    output logic               leaf_valid,
    input  logic               leaf_ready,
    output logic               leaf_last,
    output logic               busy
);

    sched_state_e       state_q, state_d;
    Triangle3D          cur_q, cur_d, rot_q, rot_d, rot_eval;
    logic [DEPTH_W-1:0] cur_depth_q, cur_depth_d;
    EdgeLenSq           d1, d2, d3, max_d;
    EdgeSel             sel;
    logic               is_leaf;

    Triangle3D          bis_out, lifo_top;
    logic [DEPTH_W-1:0] lifo_top_depth;
    logic               bis_select, lifo_push, lifo_pop, lifo_empty, lifo_full;
    logic [$clog2(MAX_DEPTH+1)-1:0] lifo_count;

    bisect u_bisect (
        .clk        (clk),
        .tri_in     (rot_q),
        .tri_select (bis_select),
        .tri_out    (bis_out)
    );

    tri_lifo #(.DEPTH(MAX_DEPTH), .DEPTH_W(DEPTH_W)) u_lifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (lifo_push),
        .pop_i        (lifo_pop),
        .push_tri_i   (bis_out),
        .push_depth_i (cur_depth_q + DEPTH_W'(1)),
        .top_tri_o    (lifo_top),
        .top_depth_o  (lifo_top_depth),
        .empty_o      (lifo_empty),
        .full_o       (lifo_full),
        .count_o      (lifo_count)
    );

    // Longest-edge selection; ties deliberately fall through to RP, then QR.
    always_comb begin
        d1 = edge_len_sq(cur_q.p, cur_q.q);
        d2 = edge_len_sq(cur_q.q, cur_q.r);
        d3 = edge_len_sq(cur_q.r, cur_q.p);
        if (d1 > d2) sel = (d1 > d3) ? EDGE_PQ : EDGE_RP;
        else         sel = (d2 > d3) ? EDGE_QR : EDGE_RP;
        case (sel)
            EDGE_PQ: begin max_d = d1; rot_eval = cur_q; end
            EDGE_QR: begin max_d = d2; rot_eval = '{p: cur_q.q, q: cur_q.r, r: cur_q.p}; end
            default: begin max_d = d3; rot_eval = '{p: cur_q.r, q: cur_q.p, r: cur_q.q}; end
        endcase
        is_leaf = (max_d <= MIN_EDGE_SQ) || (cur_depth_q == DEPTH_W'(MAX_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        cur_q       <= cur_d;
        cur_depth_q <= cur_depth_d;
        rot_q       <= rot_d;
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cur_depth_d = cur_depth_q;
        rot_d       = rot_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                cur_d       = tri_in;
                cur_depth_d = '0;
                state_d     = S_EVAL;
            end
            S_EVAL: begin
                rot_d   = rot_eval;
                state_d = is_leaf ? S_EMIT : S_SPLIT0;
            end
            S_SPLIT0: state_d = S_SPLIT1;
            S_SPLIT1: begin
                cur_d   = bis_out;
                state_d = S_SPLIT2;
            end
            S_SPLIT2: begin
                cur_depth_d = cur_depth_q + DEPTH_W'(1);
                state_d     = S_EVAL;
            end
            S_EMIT: if (leaf_ready) begin
                if (!lifo_empty) begin
                    cur_d       = lifo_top;
                    cur_depth_d = lifo_top_depth;
                    state_d     = S_EVAL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        leaf_valid = (state_q == S_EMIT);
        leaf_last  = (state_q == S_EMIT) && lifo_empty;
        leaf_out   = (state_q == S_EMIT) ? rot_q : '0;
        leaf_depth = (state_q == S_EMIT) ? cur_depth_q : '0;
        bis_select = (state_q == S_SPLIT1);
        lifo_push  = (state_q == S_SPLIT2);
        lifo_pop   = (state_q == S_EMIT) && leaf_ready && !lifo_empty;
    end

endmodule

// File: tb/tb_bisect_scheduler.sv
// Directed bench for bisect_scheduler: single-leaf vector table plus hand
// sequences for multi-leaf streams, backpressure, reset and extreme coordinates.
module tb_bisect_scheduler;
    import bisect_scheduler_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    Triangle3D tri_in;
    logic      in_valid_a, in_valid_b, leaf_ready;

    logic      a_in_ready, a_leaf_valid, a_leaf_last, a_busy;
    logic      b_in_ready, b_leaf_valid, b_leaf_last, b_busy;
    Triangle3D a_leaf_out, b_leaf_out;
    logic [2:0] a_leaf_depth;
    logic [1:0] b_leaf_depth;

    always #5 clk = ~clk;

    bisect_scheduler #(.MAX_DEPTH(4), .MIN_EDGE_SQ(35'd1024)) dut_a (
        .clk(clk), .rst(rst), .tri_in(tri_in), .in_valid(in_valid_a), .in_ready(a_in_ready),
        .leaf_out(a_leaf_out), .leaf_depth(a_leaf_depth), .leaf_valid(a_leaf_valid),
        .leaf_ready(leaf_ready), .leaf_last(a_leaf_last), .busy(a_busy)
    );

    bisect_scheduler #(.MAX_DEPTH(2), .MIN_EDGE_SQ(35'd0)) dut_b (
        .clk(clk), .rst(rst), .tri_in(tri_in), .in_valid(in_valid_b), .in_ready(b_in_ready),
        .leaf_out(b_leaf_out), .leaf_depth(b_leaf_depth), .leaf_valid(b_leaf_valid),
        .leaf_ready(leaf_ready), .leaf_last(b_leaf_last), .busy(b_busy)
    );

    // Observed-DUT mux: sel=0 watches dut_a, sel=1 watches dut_b.
    bit        sel;
    logic      o_in_ready, o_lv, o_last, o_busy, o_emit;
    Triangle3D o_leaf;
    int        o_depth, o_cnt;

    always_comb begin
        o_in_ready = sel ? b_in_ready : a_in_ready;
        o_lv       = sel ? b_leaf_valid : a_leaf_valid;
        o_last     = sel ? b_leaf_last : a_leaf_last;
        o_busy     = sel ? b_busy : a_busy;
        o_leaf     = sel ? b_leaf_out : a_leaf_out;
        o_depth    = sel ? int'(b_leaf_depth) : int'(a_leaf_depth);
        o_emit     = sel ? (dut_b.state_q == S_EMIT) : (dut_a.state_q == S_EMIT);
        o_cnt      = sel ? int'(dut_b.u_lifo.count_o) : int'(dut_a.u_lifo.count_o);
    end

    int total = 0;
    int bad = 0;
    int peak_a = 0;

    always @(posedge clk) begin
        if (int'(dut_a.u_lifo.count_o) > peak_a) peak_a = int'(dut_a.u_lifo.count_o);
    end

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(dut_a.u_lifo.push_i && dut_a.u_lifo.full_o)) else begin
                $display("FAIL lifo_push_full_a: push while full");
                bad++;
            end
            assert (!(dut_b.u_lifo.push_i && dut_b.u_lifo.full_o)) else begin
                $display("FAIL lifo_push_full_b: push while full");
                bad++;
            end
        end
    end

    function automatic Point3D pt(input int x, input int y, input int z);
        Point3D p;
        p.x = 16'(x);
        p.y = 16'(y);
        p.z = 16'(z);
        return p;
    endfunction

    function automatic Triangle3D tri3(input Point3D p, input Point3D q, input Point3D r);
        return '{p: p, q: q, r: r};
    endfunction

    task automatic chk_int(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk_tri(input string name, input Triangle3D got, input Triangle3D want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input Triangle3D t, input bit which);
        sel    = which;
        tri_in = t;
        if (which) in_valid_b = 1'b1;
        else       in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_int({tag, "_in_ready"}, o_in_ready, 1);
        chk_int({tag, "_leaf_valid"}, o_lv, 0);
        chk_int({tag, "_leaf_last"}, o_last, 0);
        chk_int({tag, "_busy"}, o_busy, 0);
        chk_tri({tag, "_leaf_out"}, o_leaf, '0);
        chk_int({tag, "_leaf_depth"}, o_depth, 0);
    endtask

    // Latency counts the cycle in which leaf_valid first appears.
    task automatic wait_leaf(input int limit, output int lat, output bit ok);
        int n = 0;
        while (!o_lv && n < limit) begin
            step();
            n++;
        end
        ok  = o_lv;
        lat = n + 1;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL leaf_timeout got=no_leaf want=leaf_valid within %0d cycles", limit);
        end
    endtask

    Triangle3D got_tri [16];
    int        got_depth [16];
    int        got_last [16];
    int        got_lat [16];

    task automatic run_stream(input int nexp, input int stall_idx, input int limit);
        int        lat;
        bit        ok;
        Triangle3D held;
        bit        held_last;
        int        held_cnt;
        for (int k = 0; k < nexp; k++) begin
            wait_leaf(limit, lat, ok);
            if (!ok) return;
            got_tri[k]   = o_leaf;
            got_depth[k] = o_depth;
            got_last[k]  = int'(o_last);
            got_lat[k]   = lat;
            if (k == stall_idx) begin
                held      = o_leaf;
                held_last = o_last;
                held_cnt  = o_cnt;
                leaf_ready = 1'b0;
                for (int s = 0; s < 7; s++) begin
                    step();
                    chk_int($sformatf("stall_hold_%0d", s),
                            int'(o_lv && o_emit && (o_leaf === held) && (o_last == held_last)
                                 && (o_cnt == held_cnt)), 1);
                end
                leaf_ready = 1'b1;
            end
            step();
        end
        chk_int("stream_end_in_ready", o_in_ready, 1);
        chk_int("stream_end_no_leaf", o_lv, 0);
    endtask

    typedef struct {
        string     name;
        Triangle3D t;
        Triangle3D exp_leaf;
        int        exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  lat;
        bit  ok;
        int  n;
        int  hits;
        EdgeLenSq d1_exp;

        vecs[0] = '{"qr_longest", tri3(pt(0,0,0), pt(10,0,0), pt(0,10,0)),
                    tri3(pt(10,0,0), pt(0,10,0), pt(0,0,0)), 2};
        vecs[1] = '{"tie_all_rp", tri3(pt(1,1,1), pt(1,1,2), pt(1,1,3)),
                    tri3(pt(1,1,3), pt(1,1,1), pt(1,1,2)), 2};
        vecs[2] = '{"pq_longest", tri3(pt(0,0,5), pt(20,0,6), pt(10,5,7)),
                    tri3(pt(0,0,5), pt(20,0,6), pt(10,5,7)), 2};
        vecs[3] = '{"edge_eq_min", tri3(pt(0,0,0), pt(32,0,0), pt(16,1,0)),
                    tri3(pt(0,0,0), pt(32,0,0), pt(16,1,0)), 2};
        vecs[4] = '{"tie_d1_d2_qr", tri3(pt(0,0,1), pt(5,0,2), pt(2,4,3)),
                    tri3(pt(5,0,2), pt(2,4,3), pt(0,0,1)), 2};
        vecs[5] = '{"negative", tri3(pt(-20,-20,-1), pt(-20,5,-2), pt(-10,-20,-3)),
                    tri3(pt(-20,5,-2), pt(-10,-20,-3), pt(-20,-20,-1)), 2};

        rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; leaf_ready = 1'b1;
        sel = 1'b0; tri_in = '0;
        repeat (3) step();
        chk_reset_vals("rst_a");
        sel = 1'b1;
        chk_reset_vals("rst_b");
        rst = 1'b0;
        step();

        // Reset while idle
        sel = 1'b0;
        rst = 1'b1;
        step();
        chk_reset_vals("rst_idle");
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].t, 1'b0);
            wait_leaf(40, lat, ok);
            if (ok) begin
                chk_int({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
                chk_tri({vecs[i].name, "_leaf"}, o_leaf, vecs[i].exp_leaf);
                chk_int({vecs[i].name, "_depth"}, o_depth, 0);
                chk_int({vecs[i].name, "_last"}, o_last, 1);
                step();
                chk_int({vecs[i].name, "_in_ready"}, o_in_ready, 1);
            end
        end

        // Just over the threshold: one split, two depth-1 leaves
        accept(tri3(pt(0,0,0), pt(32,1,0), pt(16,0,0)), 1'b0);
        run_stream(2, -1, 40);
        chk_tri("over_leaf0", got_tri[0], tri3(pt(16,0,0), pt(0,0,0), pt(16,0,0)));
        chk_tri("over_leaf1", got_tri[1], tri3(pt(32,1,0), pt(16,0,0), pt(16,0,0)));
        chk_int("over_depth0", got_depth[0], 1);
        chk_int("over_depth1", got_depth[1], 1);
        chk_int("over_last0", got_last[0], 0);
        chk_int("over_last1", got_last[1], 1);
        chk_int("over_lat0", got_lat[0], 6);
        chk_int("over_lat1", got_lat[1], 2);

        // Reset during the second SPLIT1 of dut_b (one half already pending)
        accept(tri3(pt(-8,0,0), pt(8,0,0), pt(0,8,0)), 1'b1);
        n = 0; hits = 0;
        while (hits < 2 && n < 30) begin
            if (dut_b.state_q == S_SPLIT1) hits++;
            if (hits < 2) begin
                step();
                n++;
            end
        end
        chk_int("mid_split1_reached", hits, 2);
        chk_int("mid_split1_lifo_cnt", o_cnt, 1);
        rst = 1'b1;
        step();
        chk_reset_vals("rst_split1");
        chk_int("rst_split1_lifo_cnt", o_cnt, 0);
        rst = 1'b0;
        step();
        chk_int("post_rst_in_ready", o_in_ready, 1);
        chk_int("post_rst_leaf_valid", o_lv, 0);

        // Four-leaf stream on dut_b with a 7-cycle stall on the second leaf
        accept(tri3(pt(-8,0,0), pt(8,0,0), pt(0,8,0)), 1'b1);
        run_stream(4, 1, 40);
        chk_tri("four_leaf0", got_tri[0], tri3(pt(0,0,0), pt(0,8,0), pt(-4,4,0)));
        chk_tri("four_leaf1", got_tri[1], tri3(pt(-8,0,0), pt(0,0,0), pt(-4,4,0)));
        chk_tri("four_leaf2", got_tri[2], tri3(pt(0,0,0), pt(8,0,0), pt(4,4,0)));
        chk_tri("four_leaf3", got_tri[3], tri3(pt(0,8,0), pt(0,0,0), pt(4,4,0)));
        for (int k = 0; k < 4; k++) begin
            chk_int($sformatf("four_depth%0d", k), got_depth[k], 2);
            chk_int($sformatf("four_last%0d", k), got_last[k], (k == 3) ? 1 : 0);
        end
        chk_int("four_lat0", got_lat[0], 10);
        chk_int("four_lat1", got_lat[1], 2);
        chk_int("four_lat2", got_lat[2], 6);
        chk_int("four_lat3", got_lat[3], 2);

        // Extreme coordinates on dut_a: full depth-4 tree
        peak_a = 0;
        d1_exp = 35'd2 * 35'd32766 * 35'd32766;
        accept(tri3(pt(-16383,-16383,0), pt(16383,16383,0), pt(-16383,16383,0)), 1'b0);
        chk_int("extreme_d1", longint'(dut_a.d1), longint'(d1_exp));
        run_stream(16, -1, 60);
        for (int k = 0; k < 16; k++) begin
            chk_int($sformatf("extreme_depth%0d", k), got_depth[k], 4);
            chk_int($sformatf("extreme_last%0d", k), got_last[k], (k == 15) ? 1 : 0);
        end
        chk_int("extreme_lat0", got_lat[0], 18);
        chk_int("extreme_lifo_peak", peak_a, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
